counter_sequencer: RTL and testbench

- Command-driven controller that sequences a loadable up/down counter through programmed start/end ranges, loop counts and modes: up, down, ping-pong.
- Sits between a host and the counter datapath, replacing hand-driven direction/reset toggling.
- Sequences one command at a time over a valid/ready handshake.
- Reports per-pass and end-of-command events.

---
 rtl/cnt_seq_pkg.sv | 29 ++
 rtl/updown_step_counter.sv | 34 +++
 rtl/counter_sequencer.sv | 173 +++++++++++++++++
 tb/tb_counter_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the counter sequencer: default widths, mode
// encodings, FSM state encoding and a small mode-decoding helper.
package cnt_seq_pkg;

  localparam int CNT_WIDTH_DEF = 4;
  localparam int LOOP_W_DEF    = 8;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Direction a command starts in: only down mode begins counting down;
  // the reserved encoding behaves as up.
  function automatic logic mode_initial_dir(input logic [1:0] mode);
    logic dir_s;
    case (mode)
      MODE_DOWN: dir_s = 1'b0;
      default:   dir_s = 1'b1;
    endcase
    return dir_s;
  endfunction

endpackage

// File: rtl/updown_step_counter.sv
// Loadable reversible counter. Load wins over stepping; stepping wraps
// modulo 2^WIDTH in both directions.
module updown_step_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1'b1);

  // Counter register: clear, load, or step by one in the requested direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {WIDTH{1'b0}};
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      if (dir) begin
        q <= q + STEP_ONE;
      end else begin
        q <= q - STEP_ONE;
      end
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for an up/down counter. Accepts one command at a
// time (start, end, loop count, mode) and walks the counter through the
// requested passes in up, down or ping-pong fashion, flagging each pass end
// and the completion of the command.
// Optional build macro: CNT_SEQ_PAUSE_EN adds a pause input that freezes a
// running command; without it the design behaves as if pause were tied low.
module counter_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH_DEF,
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CNT_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [WIDTH-1:0]  cmd_end,
  input  logic [LOOP_W-1:0] cmd_loops,
  input  logic [1:0]        cmd_mode,
  input  logic              abort,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_dir,
  output logic              busy,
  output logic              wrap_pulse,
  output logic              done
);

  localparam logic [LOOP_W-1:0] LOOPS_ONE  = LOOP_W'(1'b1);
  localparam logic [LOOP_W-1:0] LOOPS_ZERO = {LOOP_W{1'b0}};

  seq_state_e        state_r;
  seq_state_e        state_nxt_s;
  logic [WIDTH-1:0]  start_r;
  logic [WIDTH-1:0]  end_r;
  logic [WIDTH-1:0]  tgt_r;
  logic [WIDTH-1:0]  load_val_s;
  logic [1:0]        mode_r;
  logic [LOOP_W-1:0] loops_left_r;
  logic              dir_r;
  logic              pause_s;
  logic              at_tgt_s;
  logic              accept_s;
  logic              next_pass_s;
  logic              flip_s;
  logic              load_s;
  logic              step_en_s;

`ifdef CNT_SEQ_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign at_tgt_s   = (cnt_out == tgt_r);
  assign cmd_ready  = (state_r == IDLE) && !rst;
  assign busy       = (state_r != IDLE);
  assign wrap_pulse = (state_r == RUN) && at_tgt_s && !pause_s;
  assign done       = (state_r == DONE);
  assign cnt_dir    = dir_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus the control strobes for the datapath and counter.
  // Abort beats pause; pause beats both stepping and pass-end handling.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    next_pass_s = 1'b0;
    flip_s      = 1'b0;
    load_s      = 1'b0;
    load_val_s  = start_r;
    step_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_s    = 1'b1;
          load_s      = 1'b1;
          load_val_s  = cmd_start;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (pause_s) begin
          state_nxt_s = RUN;
        end else if (at_tgt_s) begin
          if (loops_left_r == LOOPS_ONE) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
            next_pass_s = 1'b1;
            if (mode_r == MODE_PINGPONG) begin
              // Endpoint is held for one more cycle while direction turns.
              flip_s = 1'b1;
            end else begin
              load_s     = 1'b1;
              load_val_s = start_r;
            end
          end
        end else begin
          state_nxt_s = RUN;
          step_en_s   = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Command registers, pass target, direction and remaining-pass counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_r      <= {WIDTH{1'b0}};
      end_r        <= {WIDTH{1'b0}};
      tgt_r        <= {WIDTH{1'b0}};
      mode_r       <= MODE_UP;
      loops_left_r <= LOOPS_ZERO;
      dir_r        <= 1'b1;
    end else if (accept_s) begin
      start_r      <= cmd_start;
      end_r        <= cmd_end;
      tgt_r        <= cmd_end;
      mode_r       <= cmd_mode;
      loops_left_r <= (cmd_loops == LOOPS_ZERO) ? LOOPS_ONE : cmd_loops;
      dir_r        <= mode_initial_dir(cmd_mode);
    end else if (next_pass_s) begin
      loops_left_r <= loops_left_r - LOOPS_ONE;
      if (flip_s) begin
        // Heading up means the next leg returns to start, and vice versa.
        dir_r <= ~dir_r;
        tgt_r <= dir_r ? start_r : end_r;
      end else begin
        dir_r <= dir_r;
        tgt_r <= tgt_r;
      end
    end else begin
      loops_left_r <= loops_left_r;
      dir_r        <= dir_r;
      tgt_r        <= tgt_r;
    end
  end

  updown_step_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .en       (step_en_s),
    .dir      (dir_r),
    .q        (cnt_out)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer. A pass-level reference model
// expands each command into the per-cycle values the host should see; the
// driver pushes them into a queue and a monitor checks them while busy.
module tb_counter_sequencer;
  import cnt_seq_pkg::*;

  localparam int W  = 4;
  localparam int LW = 8;
  localparam int M  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pause;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_start;
  logic [W-1:0]  cmd_end;
  logic [LW-1:0] cmd_loops;
  logic [1:0]    cmd_mode;
  logic          abort;
  logic [W-1:0]  cnt_out;
  logic          cnt_dir;
  logic          busy;
  logic          wrap_pulse;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] cnt;
    logic         dir;
    logic         wrap;
    logic         dn;
    logic         pse;
  } exp_t;

  exp_t sb_q[$];
  exp_t tr[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W), .LOOP_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CNT_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_end    (cmd_end),
    .cmd_loops  (cmd_loops),
    .cmd_mode   (cmd_mode),
    .abort      (abort),
    .cnt_out    (cnt_out),
    .cnt_dir    (cnt_dir),
    .busy       (busy),
    .wrap_pulse (wrap_pulse),
    .done       (done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expand a command into per-cycle expectations, pass by pass.
  task automatic build_trace(input logic [W-1:0] s, input logic [W-1:0] e, input int loops,
                             input logic [1:0] mode, input int pct, input int pmatch, input int plen);
    int passes, a, b, d, n, reps;
    bit pm_done;
    exp_t x;
    tr.delete();
    pm_done = 1'b0;
    passes = (loops == 0) ? 1 : loops;
    for (int p = 0; p < passes; p++) begin
      if (mode == MODE_PINGPONG) begin
        d = (p % 2 == 0) ? 1 : 0;
        a = (p % 2 == 0) ? int'(s) : int'(e);
        b = (p % 2 == 0) ? int'(e) : int'(s);
      end else begin
        d = (mode == MODE_DOWN) ? 0 : 1;
        a = int'(s);
        b = int'(e);
      end
      n = d ? (((b - a) % M) + M) % M : (((a - b) % M) + M) % M;
      for (int i = 0; i <= n; i++) begin
        x.cnt  = W'(d ? a + i : a - i);
        x.dir  = d[0];
        x.dn   = 1'b0;
        reps = 0;
        if (!pm_done && pmatch >= 0 && int'(x.cnt) == pmatch) begin
          reps = plen;
          pm_done = 1'b1;
        end else if (pct > 0 && $urandom_range(99) < pct) begin
          reps = $urandom_range(1, 3);
        end
        for (int r = 0; r < reps; r++) begin
          x.wrap = 1'b0;
          x.pse  = 1'b1;
          tr.push_back(x);
        end
        x.wrap = (i == n);
        x.pse  = 1'b0;
        tr.push_back(x);
      end
    end
    x.wrap = 1'b0;
    x.dn   = 1'b1;
    x.pse  = (pct > 0) ? 1'($urandom_range(1)) : 1'b0;
    tr.push_back(x);
  endtask

  // Issue one command, drive pause/abort/rst along its trace, then check idle.
  task automatic run_cmd(input logic [W-1:0] s, input logic [W-1:0] e, input int loops,
                         input logic [1:0] mode, input int cut, input bit use_rst,
                         input bit abort_on_accept, input int pct, input int pmatch, input int plen);
    int len;
    bit ok, rdy;
    logic [W-1:0] exp_cnt;
    logic exp_dir;
    build_trace(s, e, loops, mode, pct, pmatch, plen);
    len = (cut >= 0 && cut < tr.size()) ? cut + 1 : tr.size();
    cmd_start = s;
    cmd_end   = e;
    cmd_loops = LW'(loops);
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    abort     = abort_on_accept;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check("accept", 32'(ok), 32'd1);
    if (!ok) return;
    for (int j = 0; j < len; j++) sb_q.push_back(tr[j]);
    for (int j = 0; j < len; j++) begin
      pause     = tr[j].pse;
      abort     = (j == cut) && !use_rst;
      rst       = (j == cut) && use_rst;
      cmd_valid = ($urandom_range(7) == 0);
      if (cmd_valid) begin
        cmd_start = W'($urandom);
        cmd_end   = W'($urandom);
      end
      @(posedge clk);
      #1;
    end
    pause     = 1'b0;
    abort     = 1'b0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    #1;
    exp_cnt = use_rst && len <= cut + 1 && cut >= 0 && cut < tr.size() ? '0 : tr[len-1].cnt;
    exp_dir = use_rst && len <= cut + 1 && cut >= 0 && cut < tr.size() ? 1'b1 : tr[len-1].dir;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_cnt", 32'(cnt_out), 32'(exp_cnt));
    check("idle_dir", 32'(cnt_dir), 32'(exp_dir));
    sb_q.delete();
  endtask

  // Monitor: every busy cycle consumes one expected entry.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("busy", 32'(busy), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("cycle_out", 32'({cnt_out, cnt_dir, wrap_pulse, done}),
              32'({mon_e.cnt, mon_e.dir, mon_e.wrap, mon_e.dn}));
      end
    end else if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("busy", 32'(busy), 32'd1);
    end else if (rst === 1'b0) begin
      check("idle_pulses", 32'({wrap_pulse, done}), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int pct, cut, lp;
    logic [1:0] md;
    rst = 1'b1; pause = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    cmd_start = '0; cmd_end = '0; cmd_loops = '0; cmd_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt",   32'(cnt_out),    32'd0);
    check("rst_dir",   32'(cnt_dir),    32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_wrap",  32'(wrap_pulse), 32'd0);
    check("rst_ready", 32'(cmd_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    run_cmd(4'd3,  4'd6, 1, MODE_UP,       -1, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd9,  4'd7, 2, MODE_DOWN,     -1, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd2,  4'd5, 3, MODE_PINGPONG, -1, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd14, 4'd1, 0, MODE_UP,       -1, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd3,  4'd6, 1, MODE_UP,        1, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd3,  4'd6, 1, MODE_UP,        2, 1'b1, 1'b0, 0, -1, 0);
    run_cmd(4'd3,  4'd6, 1, MODE_UP,        4, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd5,  4'd8, 1, MODE_UP,       -1, 1'b0, 1'b1, 0, -1, 0);
    run_cmd(4'd7,  4'd7, 3, MODE_PINGPONG, -1, 1'b0, 1'b0, 0, -1, 0);
    run_cmd(4'd4,  4'd2, 2, 2'b11,         -1, 1'b0, 1'b0, 0, -1, 0);
`ifdef CNT_SEQ_PAUSE_EN
    run_cmd(4'd3,  4'd6, 1, MODE_UP,       -1, 1'b0, 1'b0, 0, 4, 3);
    pct = 15;
`else
    pct = 0;
`endif
    for (int k = 0; k < 60; k++) begin
      md  = 2'($urandom_range(3));
      lp  = $urandom_range(0, 4);
      cut = ($urandom_range(3) == 0) ? $urandom_range(0, 24) : -1;
      run_cmd(W'($urandom), W'($urandom), lp, md, cut, 1'($urandom_range(2) == 0),
              1'($urandom_range(4) == 0), pct, -1, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
